lsu_pipelined: RTL
==================

Name: lsu_pipelined

Overview:
- Parametrised load/store unit between the execute stage and a pipelined, in-order memory port (req/gnt + rvalid).
- Supports up to MAX_OUTSTANDING in-flight accesses.
- Handles byte/half/word access sizes: generates byte enables, aligns write data, extracts and sign/zero-extends read data, detects misalignment.
- Returns one response per accepted request, in order.

Parameters:
- XLEN, 32, data/address width; must be 32 or 64.
- MAX_OUTSTANDING, 2, in-flight memory accesses; power of two, >= 1.
- XLENB, XLEN/8, byte lanes; derived, not overridable.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted this cycle when valid & ready
- req_is_load_i  in  1  1 = load, 0 = store
- req_signed_i  in  1  sign-extend load result
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (XLEN=64 only)
- req_addr_i  in  XLEN  byte address
- req_wdata_i  in  XLEN  store data, LSB-aligned
- rsp_valid_o  out  1  response valid, single-cycle pulse
- rsp_is_load_o  out  1  response belongs to a load
- rsp_data_o  out  XLEN  extended load data; 0 for stores
- rsp_err_o  out  1  misaligned access (or bus error, see optional feature)
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory grant
- mem_we_o  out  1  write enable
- mem_be_o  out  XLENB  byte enables
- mem_addr_o  out  XLEN  word-aligned address (low log2(XLENB) bits zero)
- mem_wdata_o  out  XLEN  lane-shifted store data
- mem_rvalid_i  in  1  memory response valid, in grant order
- mem_rdata_i  in  XLEN  read data

Behaviour:
- Reset: rst_ni, asynchronous, active-low; clock clk_i. Reset values:
  - rsp_valid_o = 0, rsp_is_load_o = 0, rsp_data_o = 0, rsp_err_o = 0.
  - Outstanding count = 0; metadata FIFO empty.
  - Reset mid-operation discards all in-flight metadata. Any mem_rvalid_i arriving after reset is ignored, since the FIFO is empty.
- Misalignment: the address low bits are not a multiple of the size.
- Aligned issue path (combinational):
  - mem_req_o = req_valid_i & ~misaligned & (count < MAX_OUTSTANDING).
  - req_ready_o = mem_req_o & mem_gnt_i.
  - mem_be_o = size mask shifted by addr offset; mem_wdata_o = req_wdata_i shifted left by 8*offset; mem_we_o = ~req_is_load_i.
  - mem_* outputs are only meaningful while mem_req_o = 1.
- Misaligned path:
  - No memory request is issued.
  - req_ready_o = req_valid_i & (count == 0), which preserves response order.
  - Next cycle: rsp_valid_o = 1, rsp_err_o = 1, rsp_data_o = 0.
- On accept, push {is_load, signed, size, offset} into the metadata FIFO; count++.
- On mem_rvalid_i with count > 0:
  - Pop the FIFO; count--.
  - Next cycle: rsp_valid_o = 1.
  - rsp_data_o = mem_rdata_i >> 8*offset, masked to the size, then sign- or zero-extended.
  - rsp_is_load_o comes from the popped metadata.
- Latency: memory latency + 1 cycle (registered response).
- Simultaneous accept and rvalid: push and pop in the same cycle; count unchanged. Full is evaluated on the pre-cycle count, with no same-cycle bypass.
- mem_rvalid_i with count == 0: ignored. Assertion in simulation.
- A misaligned accept and an rvalid cannot occur in the same cycle, because the misaligned path requires count == 0.
- No backpressure on responses; the consumer must always accept rsp_valid_o.

Optional Feature:
- Macro: LSU_BUS_ERR_EN.
- Defined:
  - Adds input mem_err_i (1 bit), sampled with mem_rvalid_i.
  - rsp_err_o = mem_err_i for memory responses; rsp_data_o forced to 0 on error.
- Undefined: no mem_err_i port; rsp_err_o is asserted only for misalignment.

Decomposition:
- Package lsu_pkg:
  - lsu_size_e enum (SIZE_B, SIZE_H, SIZE_W, SIZE_D).
  - lsu_meta_t struct {is_load, signed, size, offset}.
  - Function for the be mask; function for load extraction/extension.
- Sub-module lsu_meta_fifo:
  - Synchronous FIFO of lsu_meta_t, depth MAX_OUTSTANDING.
  - Outputs count, full, empty.
  - Wrap-around pointers with an extra MSB.

Test Plan:
- Byte store: addr 0x1003, wdata 0xAB, size 0, gnt = 1 -> mem_addr_o 0x1000, mem_be_o 4'b1000, mem_wdata_o 0xAB000000, mem_we_o 1; rsp 1 cycle after rvalid with is_load 0.
- Signed half load: addr 0x2002, mem_rdata 0x8001_0000 -> rsp_data_o 0xFFFF8001. Same access unsigned -> 0x00008001.
- Back-to-back: 3 loads with MAX_OUTSTANDING = 2 and rvalid delayed 4 cycles -> third request held (req_ready_o = 0) until the first rvalid; responses in issue order.
- Misaligned word load: addr 0x3002 issued while 1 access is outstanding -> stalled until count = 0, no mem_req_o; then rsp_err_o = 1, rsp_data_o 0.
- Simultaneous push/pop at count = 2 with gnt and rvalid both high -> no accept that cycle; count goes to 1; accept on the next cycle.
- Reset asserted with 2 outstanding, then rvalid pulses -> no rsp_valid_o. With LSU_BUS_ERR_EN: mem_err_i = 1 on rvalid -> rsp_err_o 1, rsp_data_o 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the pipelined load/store unit.
//   lsu_size_e    : access size encoding (byte/half/word/dword)
//   lsu_meta_t    : per-access metadata carried from issue to response
//   size_mask     : byte-lane mask for an access size, LSB-aligned
//   be_mask       : byte enables for a size at a given lane offset
//   is_misaligned : offset not a multiple of the access size
//   load_extract  : lane-shift, size-mask and sign/zero-extend read data
// Helpers work on 64-bit values; callers truncate to XLEN.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } lsu_size_e;

  typedef struct packed {
    logic      is_load;
    logic      sign_ext;
    lsu_size_e size;
    logic [2:0] offset;
  } lsu_meta_t;

  function automatic logic [7:0] size_mask(lsu_size_e size);
    logic [7:0] m;
    case (size)
      SIZE_B:  m = 8'h01;
      SIZE_H:  m = 8'h03;
      SIZE_W:  m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] be_mask(lsu_size_e size, logic [2:0] offset);
    return size_mask(size) << offset;
  endfunction

  // dword_ok is 0 on a 32-bit datapath, where a dword access can never be
  // issued as a single beat and is reported like a misaligned access.
  function automatic logic is_misaligned(lsu_size_e size, logic [2:0] offset,
                                         logic dword_ok);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = offset[0];
      SIZE_W:  mis = |offset[1:0];
      default: mis = ~dword_ok | (|offset);
    endcase
    return mis;
  endfunction

  function automatic logic [63:0] load_extract(logic [63:0] rdata, lsu_meta_t meta);
    logic [63:0] sh;
    logic [63:0] res;
    sh = rdata >> {meta.offset, 3'b000};
    case (meta.size)
      SIZE_B:  res = {{56{meta.sign_ext & sh[7]}},  sh[7:0]};
      SIZE_H:  res = {{48{meta.sign_ext & sh[15]}}, sh[15:0]};
      SIZE_W:  res = {{32{meta.sign_ext & sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_pipelined_if.sv
// Memory-side bus of the load/store unit: pipelined req/gnt issue channel
// plus in-order rvalid response channel.
//   master : LSU side (drives req/we/be/addr/wdata)
//   slave  : memory side (drives gnt/rvalid/rdata[/err])
// Optional: LSU_BUS_ERR_EN adds the err response bit, sampled with rvalid.
interface lsu_pipelined_if #(
  parameter int XLEN = 32
);
  localparam int XLENB = XLEN / 8;

  logic             req;
  logic             gnt;
  logic             we;
  logic [XLENB-1:0] be;
  logic [XLEN-1:0]  addr;
  logic [XLEN-1:0]  wdata;
  logic             rvalid;
  logic [XLEN-1:0]  rdata;
`ifdef LSU_BUS_ERR_EN
  logic             err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
`else
  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
`endif

endinterface

// File: rtl/lsu_meta_fifo.sv
// Synchronous FIFO of access metadata, one entry per in-flight access.
//   push_i/push_data_i : write an entry (ignored when full)
//   pop_i/pop_data_o   : head entry, removed on pop_i (ignored when empty)
//   count_o/full_o/empty_o : occupancy
// DEPTH must be a power of two; pointers carry one extra wrap bit so that
// occupancy is simply the pointer difference.
module lsu_meta_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  lsu_meta_t     push_data_i,
  input  logic          pop_i,
  output lsu_meta_t     pop_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int IW = (AW == 0) ? 1 : AW;
  localparam logic [CW-1:0] IDX_MASK = CW'(DEPTH - 1);

  lsu_meta_t       mem_q [DEPTH];
  logic [CW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [IW-1:0]   wr_idx, rd_idx;
  logic            push_en, pop_en;

  assign wr_idx  = IW'(wr_ptr_q & IDX_MASK);
  assign rd_idx  = IW'(rd_ptr_q & IDX_MASK);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  assign pop_data_o = mem_q[rd_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + CW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + CW'(1);
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_idx] <= push_data_i;
  end

endmodule

// File: rtl/lsu_pipelined.sv
// Pipelined load/store unit between execute and an in-order req/gnt +
// rvalid memory port. Up to MAX_OUTSTANDING accesses in flight; one
// registered response per accepted request, in request order.
//   clk_i, rst_ni            : clock, async active-low reset
//   req_*                    : request from execute (valid/ready handshake)
//   rsp_*                    : single-cycle response pulse, no backpressure
//   mem                      : memory bus (lsu_pipelined_if.master)
// Parameters: XLEN (32 or 64), MAX_OUTSTANDING (power of two, >= 1).
// Optional: LSU_BUS_ERR_EN routes the memory error bit to rsp_err_o and
// forces rsp_data_o to zero on error.
// Misaligned accesses never reach memory; they wait for the unit to drain
// so their error response stays in order, then respond one cycle later.
module lsu_pipelined
  import lsu_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,

  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_is_load_i,
  input  logic            req_signed_i,
  input  logic [1:0]      req_size_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,

  output logic            rsp_valid_o,
  output logic            rsp_is_load_o,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            rsp_err_o,

  lsu_pipelined_if.master mem
);

  localparam int XLENB = XLEN / 8;
  localparam int OFFW  = $clog2(XLENB);
  localparam int CW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic DWORD_OK = (XLEN == 64);

  lsu_size_e     req_size;
  logic [2:0]    req_offset;
  logic          misaligned;
  logic [7:0]    be_full;

  logic          push, pop;
  lsu_meta_t     push_meta, pop_meta;
  logic [CW-1:0] count;
  logic          full, empty;

  logic          mis_accept;
  logic          bus_err;
  logic [63:0]   rdata_ext;
  logic [63:0]   ld_full;
  logic [XLEN-1:0] ld_data;

  assign req_size   = lsu_size_e'(req_size_i);
  assign req_offset = 3'(req_addr_i[OFFW-1:0]);
  assign misaligned = is_misaligned(req_size, req_offset, DWORD_OK);
  assign be_full    = be_mask(req_size, req_offset);

  // Issue path; full is the registered occupancy, so a pop in this cycle
  // does not free a slot until the next one.
  assign mem.req   = req_valid_i & ~misaligned & ~full;
  assign mem.we    = ~req_is_load_i;
  assign mem.be    = XLENB'(be_full);
  assign mem.addr  = {req_addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign mem.wdata = req_wdata_i << {req_offset, 3'b000};

  assign mis_accept  = req_valid_i & misaligned & (count == '0);
  assign req_ready_o = misaligned ? mis_accept : (mem.req & mem.gnt);

  assign push = mem.req & mem.gnt;
  assign pop  = mem.rvalid & ~empty;

  assign push_meta = '{is_load:  req_is_load_i,
                       sign_ext: req_signed_i,
                       size:     req_size,
                       offset:   req_offset};

  lsu_meta_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_meta_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (push_meta),
    .pop_i       (pop),
    .pop_data_o  (pop_meta),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

`ifdef LSU_BUS_ERR_EN
  assign bus_err = mem.err;
`else
  assign bus_err = 1'b0;
`endif

  assign rdata_ext = 64'(mem.rdata);
  assign ld_full   = load_extract(rdata_ext, pop_meta);
  assign ld_data   = XLEN'(ld_full);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o   <= 1'b0;
      rsp_is_load_o <= 1'b0;
      rsp_data_o    <= '0;
      rsp_err_o     <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      if (pop) begin
        rsp_valid_o   <= 1'b1;
        rsp_is_load_o <= pop_meta.is_load;
        rsp_err_o     <= bus_err;
        rsp_data_o    <= (bus_err | ~pop_meta.is_load) ? '0 : ld_data;
      end else if (mis_accept) begin
        rsp_valid_o   <= 1'b1;
        rsp_is_load_o <= req_is_load_i;
        rsp_err_o     <= 1'b1;
        rsp_data_o    <= '0;
      end
    end
  end

  // A response with nothing in flight means the memory side broke ordering.
  a_no_spurious_rvalid : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(mem.rvalid && empty)
  );

endmodule
